// File: rtl/controller_pkg.sv
// controller_pkg: channel indices and defaults shared by the controller input stage.
package controller_pkg;
  localparam int NUM_CH = 6;
  localparam int CH_LEFT = 0;
  localparam int CH_RIGHT = 1;
  localparam int CH_UP = 2;
  localparam int CH_DOWN = 3;
  localparam int CH_ATTACK = 4;
  localparam int CH_SHIELD = 5;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 1_000_000;
endpackage

// File: rtl/debounce_channel.sv
// debounce_channel: 2-flop synchroniser, stable-time counter and rising-edge press pulse.
module debounce_channel #(
  parameter int DEBOUNCE_CYCLES = controller_pkg::DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  output logic clean_o,
  output logic press_o
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
  logic [1:0] sync_q, sync_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic clean_q, clean_d, press_q, press_d, match, done;
  always_comb begin
    sync_d = {sync_q[0], raw_i};
    match = sync_q[1] == clean_q;
    done = cnt_q == CNT_MAX;
    cnt_d = (match || done) ? '0 : cnt_q + CW'(1);
    clean_d = (!match && done) ? sync_q[1] : clean_q;
    // pulse is registered alongside the clean rise so both appear on the same cycle
    press_d = !match && done && sync_q[1];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      cnt_q <= '0;
      clean_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q <= cnt_d;
      clean_q <= clean_d;
      press_q <= press_d;
    end
  end
  assign clean_o = clean_q;
  assign press_o = press_q;
endmodule

// File: rtl/controller_debounce.sv
// controller_debounce: normalises the six JX header pins and debounces each into clean levels and press pulses.
module controller_debounce
  import controller_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic jx1_left,
  input  logic jx2_right,
  input  logic jx3_up,
  input  logic jx4_down,
  input  logic jx9_attack,
  input  logic jx10_shield,
  output logic left,
  output logic right,
  output logic up,
  output logic down,
  output logic attack,
  output logic shield,
  output logic attack_press,
  output logic shield_press
);
  logic [NUM_CH-1:0] raw, clean, press;
  logic unused_press;
  // direction pins are active-low on the header
  assign raw[CH_LEFT] = ~jx1_left;
  assign raw[CH_RIGHT] = ~jx2_right;
  assign raw[CH_UP] = ~jx3_up;
  assign raw[CH_DOWN] = ~jx4_down;
  assign raw[CH_ATTACK] = jx9_attack;
  assign raw[CH_SHIELD] = jx10_shield;
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ch (
      .clk(clk),
      .rst_n(rst_n),
      .raw_i(raw[i]),
      .clean_o(clean[i]),
      .press_o(press[i])
    );
  end
  assign left = clean[CH_LEFT];
  assign right = clean[CH_RIGHT];
  assign up = clean[CH_UP];
  assign down = clean[CH_DOWN];
  assign attack = clean[CH_ATTACK];
  assign shield = clean[CH_SHIELD];
  assign attack_press = press[CH_ATTACK];
  assign shield_press = press[CH_SHIELD];
  assign unused_press = ^press[CH_DOWN:CH_LEFT];
endmodule

// File: tb/tb_controller_debounce.sv
// tb_controller_debounce: directed edge-by-edge checks of the debounce stage with DEBOUNCE_CYCLES = 8.
module tb_controller_debounce;
  logic clk = 1'b0;
  logic rst_n;
  logic jx1_left, jx2_right, jx3_up, jx4_down, jx9_attack, jx10_shield;
  logic left, right, up, down, attack, shield, attack_press, shield_press;
  logic [7:0] outs;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  controller_debounce #(.DEBOUNCE_CYCLES(8)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .jx1_left(jx1_left),
    .jx2_right(jx2_right),
    .jx3_up(jx3_up),
    .jx4_down(jx4_down),
    .jx9_attack(jx9_attack),
    .jx10_shield(jx10_shield),
    .left(left),
    .right(right),
    .up(up),
    .down(down),
    .attack(attack),
    .shield(shield),
    .attack_press(attack_press),
    .shield_press(shield_press)
  );
  // {left,right,up,down,attack,shield,attack_press,shield_press}
  assign outs = {left, right, up, down, attack, shield, attack_press, shield_press};
  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %b expected %b", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask
  initial begin
    rst_n = 1'b0;
    {jx1_left, jx2_right, jx3_up, jx4_down} = 4'b1111;
    {jx9_attack, jx10_shield} = 2'b00;
    repeat (3) tick();
    check("reset", outs, 8'h00);
    rst_n = 1'b1;
    for (int e = 0; e < 20; e++) begin
      tick();
      check("post_reset_idle", outs, 8'h00);
    end
    jx1_left = 1'b0;
    for (int e = 0; e <= 10; e++) begin
      tick();
      check($sformatf("left_press_e%0d", e), outs, e >= 9 ? 8'b1000_0000 : 8'h00);
    end
    jx1_left = 1'b1;
    repeat (10) tick();
    check("left_release", outs, 8'h00);
    for (int i = 0; i < 10; i++) begin
      jx9_attack = ~i[0];
      repeat (3) begin
        tick();
        check("bounce", outs, 8'h00);
      end
    end
    jx9_attack = 1'b1;
    for (int e = 0; e <= 10; e++) begin
      tick();
      check($sformatf("bounce_settle_e%0d", e), outs,
            e == 9 ? 8'b0000_1010 : (e > 9 ? 8'b0000_1000 : 8'h00));
    end
    jx9_attack = 1'b0;
    for (int e = 0; e < 10; e++) begin
      tick();
      check("attack_release", outs, e >= 9 ? 8'h00 : 8'b0000_1000);
    end
    jx10_shield = 1'b1;
    repeat (7) tick();
    jx10_shield = 1'b0;
    for (int e = 0; e < 12; e++) begin
      tick();
      check("glitch7", outs, 8'h00);
    end
    jx10_shield = 1'b1;
    for (int e = 0; e < 20; e++) begin
      if (e == 8) jx10_shield = 1'b0;
      tick();
      check($sformatf("glitch8_e%0d", e), outs,
            e == 9 ? 8'b0000_0101 : ((e > 9 && e < 17) ? 8'b0000_0100 : 8'h00));
    end
    {jx9_attack, jx10_shield} = 2'b11;
    for (int e = 0; e <= 10; e++) begin
      tick();
      check($sformatf("simul_e%0d", e), outs,
            e == 9 ? 8'b0000_1111 : (e > 9 ? 8'b0000_1100 : 8'h00));
    end
    {jx9_attack, jx10_shield} = 2'b00;
    repeat (10) tick();
    check("simul_release", outs, 8'h00);
    jx2_right = 1'b0;
    repeat (10) tick();
    check("right_held", outs, 8'b0100_0000);
    jx3_up = 1'b0;
    repeat (5) tick();
    check("up_counting", outs, 8'b0100_0000);
    #2 rst_n = 1'b0;
    #1 check("async_reset", outs, 8'h00);
    @(negedge clk);
    check("reset_hold", outs, 8'h00);
    rst_n = 1'b1;
    for (int e = 0; e <= 10; e++) begin
      tick();
      check($sformatf("post_reset_e%0d", e), outs, e >= 9 ? 8'b0110_0000 : 8'h00);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/controller_debounce.md
# controller_debounce

Input-conditioning stage that sits directly upstream of the player controller decoder. It takes the six raw Nexys A7 JX header pins (joystick directions and attack/shield buttons), synchronises each into the `clk` domain and debounces it with a per-channel stable-time counter. It presents clean active-high levels, plus single-cycle press pulses for attack and shield, to the controller decoder and the game logic.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, 1_000_000: consecutive stable cycles required before a clean output changes (10 ms at 100 MHz); legal range >= 2.

Ports:
- `clk` input 1: main 100 MHz clock.
- `rst_n` input 1: reset, asynchronous, active-low.
- `jx1_left` input 1: raw left, active-low.
- `jx2_right` input 1: raw right, active-low.
- `jx3_up` input 1: raw up, active-low.
- `jx4_down` input 1: raw down, active-low.
- `jx9_attack` input 1: raw attack button, active-high.
- `jx10_shield` input 1: raw shield button, active-high.
- `left`, `right`, `up`, `down` output 1 each: debounced direction, active-high.
- `attack`, `shield` output 1 each: debounced button level, active-high.
- `attack_press`, `shield_press` output 1 each: one-cycle pulse on a debounced 0->1 transition.

## Operation
- **Normalisation:** direction pins are inverted at the input, so every channel is treated as active-high internally.
- **Synchronisation:** each channel passes through a 2-flop synchroniser; the second flop output is the sample `s`.
- **Per-channel debounce:** state is `clean` (1 bit) and `cnt` (width `$clog2(DEBOUNCE_CYCLES)`). On each edge:
  - if `s == clean`: `cnt <= 0`;
  - else if `cnt == DEBOUNCE_CYCLES-1`: `clean <= s`, `cnt <= 0`;
  - else: `cnt <= cnt + 1`.
- **Glitch filtering:**
  - Any disagreement shorter than `DEBOUNCE_CYCLES` cycles at `s` restarts the count and is discarded.
  - A disagreement of exactly `DEBOUNCE_CYCLES` cycles is accepted.
- **Press pulses:**
  - `attack_press` is registered high in the same edge that moves attack `clean` from 0 to 1, so it is coincident with the first cycle `attack` reads 1.
  - It is low on every other cycle. Release produces no pulse.
  - `shield_press` behaves the same way for the shield channel.
- **Channel independence:** channels never interact. Simultaneous events on several channels produce simultaneous outputs.
- **Counter arithmetic:** `cnt` never exceeds `DEBOUNCE_CYCLES-1` and never wraps.
- **Reset values** (all asserted asynchronously while `rst_n` is low):
  - synchroniser flops: 0, i.e. inactive after normalisation;
  - `clean`: 0, `cnt`: 0;
  - all outputs: 0.
- **Reset mid-count:** a count in progress is discarded.
- **Held input across reset:** an input already held active when `rst_n` deasserts is seen as a new press. It yields the level plus a press pulse after the full debounce time.

## Timing
- **Latency:** a raw level change first sampled at edge k appears on the clean output at edge k + `DEBOUNCE_CYCLES` + 1. This covers 2 synchroniser edges plus `DEBOUNCE_CYCLES` count edges, minus the overlap of the first count edge.
- **Press pulse:** same edge as the clean rise; width is exactly 1 cycle.
- **Output registration:** all outputs are registered; no combinational path from any `jx*` pin to an output.
- **Repeat rate:** minimum spacing between two press pulses on one channel is 2·`DEBOUNCE_CYCLES` cycles (press, then release, both debounced).

## Structure
- **Shared package `controller_pkg`:**
  - channel index constants (`CH_LEFT`..`CH_SHIELD`, 0..5);
  - `NUM_CH = 6`;
  - default `DEBOUNCE_CYCLES`.
- **Sub-module `debounce_channel`:** one instance per channel, parameterised by `DEBOUNCE_CYCLES`.
  - Contains the synchroniser, counter, `clean` register and rising-edge pulse.
  - All six channels are instantiated in a generate loop.
- **Top level:** does input inversion and output naming only.

## Test plan
All scenarios run with `DEBOUNCE_CYCLES = 8`.
- **Reset:** hold `rst_n` = 0 with `jx1_left`..`jx4_down` = 1 and `jx9_attack`, `jx10_shield` = 0 -> every output 0. Outputs stay 0 for 20 cycles after release.
- **Clean press:** drive `jx1_left` 1->0 before edge 0 and hold -> `left` = 0 through edge 8 and `left` = 1 from edge 9. No pulse outputs toggle.
- **Bounce:** toggle `jx9_attack` every 3 cycles for 30 cycles, then hold 1 -> no `attack` change during bouncing. `attack` rises 9 edges after the final transition, with exactly one `attack_press` pulse coincident with it.
- **Glitch width:** pulse `jx10_shield` high for 7 cycles -> `shield` stays 0. Pulse it high for 8 cycles -> `shield` rises and `shield_press` fires once. `shield` then falls 9 edges after the pin returns to 0.
- **Simultaneous:** raise `jx9_attack` and `jx10_shield` on the same edge -> `attack_press` and `shield_press` high in the same single cycle.
- **Reset mid-operation:** assert `rst_n` low 5 cycles into a `jx3_up` press with the pin held low -> `up` and all counters go 0 immediately (asynchronously). After release, `up` rises exactly 9 edges after the first post-reset edge.
